// File: rtl/feed_sequencer.sv
// Feed sequencer: buffers one operand tile and drives the west-edge data_feeder row with a diagonal skew.
// Optional FEED_SEQ_STATS_EN adds tiles_done / stall_cycles counters.
module feed_sequencer #(
  parameter int N_LANES      = 7,
  parameter int VEC_LEN      = 7,
  parameter int ELEM_W       = 8,
  parameter int DRAIN_CYCLES = 7
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [VEC_LEN*ELEM_W-1:0]           in_row,
  output logic [N_LANES*VEC_LEN*ELEM_W-1:0]   feed_data,
  output logic [N_LANES-1:0]                  feed_load,
  output logic [N_LANES-1:0]                  feed_shift,
  output logic [N_LANES-1:0]                  lane_valid,
  output logic                                busy,
  output logic                                tile_done
`ifdef FEED_SEQ_STATS_EN
  ,
  output logic [15:0]                         tiles_done,
  output logic [15:0]                         stall_cycles
`endif
);

  localparam int ROW_W = VEC_LEN * ELEM_W;
  localparam int RW    = $clog2(N_LANES + 1);
  localparam int TW    = $clog2(N_LANES + VEC_LEN + 1);
  localparam int DW    = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(N_LANES - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(N_LANES + VEC_LEN - 1);
  localparam logic [DW-1:0] D_LAST   = (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [RW-1:0]       row_cnt_q, row_cnt_d;
  logic [TW-1:0]       t_q, t_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic [ROW_W-1:0]    bank_q [N_LANES];
  logic [ROW_W-1:0]    bank_d [N_LANES];
  logic [N_LANES-1:0]  load_d, shift_d, valid_d;
  logic                busy_d, done_d;

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    t_d       = t_q;
    drain_d   = drain_q;
    bank_d    = bank_q;
    case (state_q)
      S_IDLE, S_FILL: begin
        if (in_valid) begin
          for (int r = 0; r < N_LANES; r++) begin
            if (32'(row_cnt_q) == r) bank_d[r] = in_row;
          end
          row_cnt_d = row_cnt_q + 1'b1;
          if (row_cnt_q == ROW_LAST) begin
            state_d = S_STREAM;
            t_d     = '0;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_STREAM: begin
        if (t_q == T_LAST) begin
          if (DRAIN_CYCLES == 0) begin
            state_d   = S_IDLE;
            row_cnt_d = '0;
          end else begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == D_LAST) begin
          state_d   = S_IDLE;
          row_cnt_d = '0;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so the registered outputs line up with the current t.
  always_comb begin
    load_d  = '0;
    shift_d = '0;
    valid_d = '0;
    busy_d  = (state_d == S_STREAM) || (state_d == S_DRAIN);
    for (int r = 0; r < N_LANES; r++) begin
      if (state_d == S_STREAM) begin
        load_d[r]  = (32'(t_d) == r);
        shift_d[r] = (32'(t_d) >= r + 1) && (32'(t_d) <= r + VEC_LEN - 1);
        valid_d[r] = (32'(t_d) >= r + 1) && (32'(t_d) <= r + VEC_LEN);
      end
    end
    if (DRAIN_CYCLES == 0) begin
      done_d = (state_d == S_STREAM) && (t_d == T_LAST);
    end else begin
      done_d = (state_d == S_DRAIN) && (drain_d == D_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      row_cnt_q  <= '0;
      t_q        <= '0;
      drain_q    <= '0;
      bank_q     <= '{default: '0};
      feed_load  <= '0;
      feed_shift <= '0;
      lane_valid <= '0;
      busy       <= 1'b0;
      tile_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      t_q        <= t_d;
      drain_q    <= drain_d;
      bank_q     <= bank_d;
      feed_load  <= load_d;
      feed_shift <= shift_d;
      lane_valid <= valid_d;
      busy       <= busy_d;
      tile_done  <= done_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) || (state_q == S_FILL);
    feed_data = '0;
    for (int r = 0; r < N_LANES; r++) begin
      feed_data[r*ROW_W +: ROW_W] = bank_q[r];
    end
  end

`ifdef FEED_SEQ_STATS_EN
  logic [15:0] tiles_q, tiles_d, stall_q, stall_d;

  // Tile count wraps; stall count saturates.
  always_comb begin
    tiles_d = done_d ? tiles_q + 16'd1 : tiles_q;
    stall_d = stall_q;
    if (in_valid && !in_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tiles_q <= 16'd0;
      stall_q <= 16'd0;
    end else begin
      tiles_q <= tiles_d;
      stall_q <= stall_d;
    end
  end

  assign tiles_done   = tiles_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_feed_sequencer.sv
// Directed bench for feed_sequencer: table-driven single tile plus gapped, back-pressure and reset sequences.
module tb_feed_sequencer;
  localparam int NL = 7;
  localparam int VL = 7;
  localparam int EW = 8;
  localparam int RWD = VL * EW;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [RWD-1:0]       in_row;
  logic [NL*RWD-1:0]    feed_data;
  logic [NL-1:0]        feed_load, feed_shift, lane_valid;
  logic                 busy, tile_done;
`ifdef FEED_SEQ_STATS_EN
  logic [15:0]          tiles_done, stall_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;

  feed_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .feed_data(feed_data), .feed_load(feed_load), .feed_shift(feed_shift),
    .lane_valid(lane_valid), .busy(busy), .tile_done(tile_done)
`ifdef FEED_SEQ_STATS_EN
    , .tiles_done(tiles_done), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           in_valid;
    logic [RWD-1:0] in_row;
    logic           exp_ready;
    logic [NL-1:0]  exp_load;
    logic [NL-1:0]  exp_shift;
    logic [NL-1:0]  exp_valid;
    logic           exp_busy;
    logic           exp_done;
  } vec_t;

  vec_t tbl [28];

  function automatic logic [RWD-1:0] row_word(input int r);
    logic [RWD-1:0] w;
    w = '0;
    for (int k = 0; k < VL; k++) w[(VL-1-k)*EW +: EW] = 8'(r * 16 + k + 1);
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_rows(input int first, input int base);
    for (int r = first; r < NL; r++) begin
      in_valid = 1'b1;
      in_row   = row_word(base + r);
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [NL*RWD-1:0] exp_fd;
    int cnt;

    // Cycle i of the table is observed after edge i; the last row is accepted at edge 6 (E).
    for (int i = 0; i < 28; i++) begin
      int  t;
      bit  strm, drn;
      t    = i - 6;
      strm = (i >= 6) && (i <= 19);
      drn  = (i >= 20) && (i <= 26);
      tbl[i].in_valid  = (i < 7);
      tbl[i].in_row    = (i < 7) ? row_word(i) : '0;
      tbl[i].exp_ready = !(strm || drn);
      tbl[i].exp_busy  = strm || drn;
      tbl[i].exp_done  = (i == 26);
      tbl[i].exp_load  = '0;
      tbl[i].exp_shift = '0;
      tbl[i].exp_valid = '0;
      for (int r = 0; r < NL; r++) begin
        if (strm) begin
          tbl[i].exp_load[r]  = (t == r);
          tbl[i].exp_shift[r] = (t >= r + 1) && (t <= r + VL - 1);
          tbl[i].exp_valid[r] = (t >= r + 1) && (t <= r + VL);
        end
      end
    end

    reset = 1'b1; in_valid = 1'b0; in_row = '0;
    step(); step();
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_load", feed_load, '0);
    chk("rst_shift", feed_shift, '0);
    chk("rst_valid", lane_valid, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", tile_done, 1'b0);
    chk("rst_data", feed_data, '0);
    reset = 1'b0;

    for (int i = 0; i < 28; i++) begin
      in_valid = tbl[i].in_valid;
      in_row   = tbl[i].in_row;
      step();
      chk($sformatf("v%0d_ready", i), in_ready, tbl[i].exp_ready);
      chk($sformatf("v%0d_load", i), feed_load, tbl[i].exp_load);
      chk($sformatf("v%0d_shift", i), feed_shift, tbl[i].exp_shift);
      chk($sformatf("v%0d_valid", i), lane_valid, tbl[i].exp_valid);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].exp_busy);
      chk($sformatf("v%0d_done", i), tile_done, tbl[i].exp_done);
    end
    in_valid = 1'b0;
    for (int r = 0; r < NL; r++) chk($sformatf("tile1_lane%0d", r), feed_data[r*RWD +: RWD], row_word(r));

    // Gapped input: three idle cycles between rows 2 and 3.
    for (int r = 0; r < NL; r++) begin
      if (r == 3) begin
        in_valid = 1'b0;
        repeat (3) begin
          step();
          chk("gap_ready", in_ready, 1'b1);
          chk("gap_busy", busy, 1'b0);
        end
      end
      in_valid = 1'b1;
      in_row   = row_word(8 + r);
      step();
      chk($sformatf("gap_load_r%0d", r), feed_load, (r == NL - 1) ? 7'b0000001 : 7'b0000000);
      chk($sformatf("gap_busy_r%0d", r), busy, r == NL - 1);
    end
    in_valid = 1'b0;
    cnt = 1;
    while (!tile_done && cnt < 40) begin
      step();
      cnt++;
    end
    chk("gap_done_latency", cnt, 21);
    chk("gap_lane3", feed_data[3*RWD +: RWD], row_word(11));
    step();

    // Back-pressure: a row held through STREAM/DRAIN lands as row 0 of the next tile.
    send_rows(0, 0);
    for (int r = 0; r < NL; r++) exp_fd[r*RWD +: RWD] = row_word(r);
    in_valid = 1'b1;
    in_row   = {RWD/8{8'hAA}};
    for (int c = 1; c <= 21; c++) begin
      chk($sformatf("bp_ready_c%0d", c), in_ready, 1'b0);
      chk($sformatf("bp_done_c%0d", c), tile_done, c == 21);
      chk($sformatf("bp_bank_c%0d", c), feed_data, exp_fd);
      step();
    end
    chk("bp_ready_rise", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("bp_row0", feed_data[0 +: RWD], {RWD/8{8'hAA}});
    chk("bp_row1_kept", feed_data[RWD +: RWD], row_word(1));
    chk("bp_fill_busy", busy, 1'b0);
    chk("bp_fill_ready", in_ready, 1'b1);

    // Mid-stream reset at t=5.
    send_rows(1, 0);
    chk("mr_t0_load", feed_load, 7'b0000001);
    repeat (5) step();
    chk("mr_t5_load", feed_load, 7'b0100000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_load", feed_load, '0);
    chk("mr_shift", feed_shift, '0);
    chk("mr_valid", lane_valid, '0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_ready", in_ready, 1'b1);
    chk("mr_data", feed_data, '0);
    for (int c = 0; c < 30; c++) begin
      step();
      chk($sformatf("mr_nodone_c%0d", c), {busy, tile_done}, 2'b00);
    end

`ifdef FEED_SEQ_STATS_EN
    chk("st_zero", {tiles_done, stall_cycles}, 32'd0);
    repeat (3) begin
      send_rows(0, 0);
      in_valid = 1'b1;
      in_row   = {RWD/8{8'hAA}};
      repeat (21) step();
      in_valid = 1'b0;
      step();
    end
    chk("st_tiles", tiles_done, 16'd3);
    chk("st_stalls", stall_cycles, 16'd63);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/feed_sequencer.md
# feed_sequencer

Upstream controller for the row of `data_feeder` shift registers at the west edge of the systolic MAC array. It accepts one operand tile row by row over a valid/ready handshake and holds the rows in a register bank. It then drives each feeder's `data_in`, `load` and `shift` with a one-cycle diagonal skew per lane, so that element k of lane r reaches the array at stream cycle r+k+1. Once the array has been allowed to flush, it signals tile completion.

## Interface
- `N_LANES`, default 7: number of feeders/array rows driven.
- `VEC_LEN`, default 7: elements per row word.
- `ELEM_W`, default 8: element width in bits.
- `DRAIN_CYCLES`, default 7: idle cycles after streaming, so the array can flush partial sums.
- `clk` input 1: single clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: a row word is offered.
- `in_ready` output 1: a row word can be accepted. A transfer occurs when `in_valid` and `in_ready` are both high at the clock edge.
- `in_row` input VEC_LEN*ELEM_W: row word, element 0 in the MSBs.
- `feed_data` output N_LANES*VEC_LEN*ELEM_W: lane r is bits [(r+1)*VEC_LEN*ELEM_W-1 -: VEC_LEN*ELEM_W] and drives feeder r's `data_in`.
- `feed_load` output N_LANES: per-lane `load` to the feeders.
- `feed_shift` output N_LANES: per-lane `shift` to the feeders.
- `lane_valid` output N_LANES: high while feeder r's `data_out` holds a real element.
- `busy` output 1: high in STREAM and DRAIN.
- `tile_done` output 1: one-cycle pulse when a tile completes.

## Operation
- **States:**
  - IDLE: wait for the first row.
  - FILL: collect rows.
  - STREAM: issue skewed loads and shifts.
  - DRAIN: wait for the array to flush.
- **IDLE/FILL:**
  - `in_ready`=1.
  - Each accepted row is written to bank[row_cnt], and row_cnt increments.
  - The first accept moves IDLE to FILL.
  - The accept that makes row_cnt reach N_LANES moves to STREAM, with t=0 on the next cycle.
  - If N_LANES=1, the single accept goes directly from IDLE to STREAM.
- **STREAM:**
  - `in_ready`=0; t counts 0 .. N_LANES+VEC_LEN-1.
  - `feed_load[r]`=1 only when t==r.
  - `feed_shift[r]`=1 when r+1 ≤ t ≤ r+VEC_LEN-1.
  - `lane_valid[r]`=1 when r+1 ≤ t ≤ r+VEC_LEN. This tracks the registered feeder output.
  - After the last t, go to DRAIN.
- **DRAIN:**
  - `in_ready`=0 for DRAIN_CYCLES cycles.
  - On the final DRAIN cycle, `tile_done`=1.
  - Then return to IDLE, clearing row_cnt.
  - If DRAIN_CYCLES=0, `tile_done` pulses on the last STREAM cycle instead.
- **Data path:**
  - `feed_data` is driven from the bank continuously.
  - Bank contents persist after a tile until they are overwritten by the next FILL.
- Load and shift are never asserted together for a lane. Load takes the cycle t==r, and shifting starts at t==r+1.
- Rows offered during STREAM/DRAIN are back-pressured. Nothing is dropped and nothing is overwritten.
- **Counters:**
  - row_cnt is $clog2(N_LANES+1) bits.
  - t is $clog2(N_LANES+VEC_LEN+1) bits.
  - The drain counter is $clog2(DRAIN_CYCLES+1) bits.
  - None of the counters wrap within a tile.

## Timing
- **Reset values:**
  - state=IDLE, row_cnt=0, bank all zeros, so `feed_data`=0.
  - `in_ready`=1.
  - `feed_load`, `feed_shift`, `lane_valid`, `busy` and `tile_done` all 0.
- **Reset and simultaneous events:**
  - `reset` takes priority over any handshake in the same cycle.
  - Reset during STREAM or DRAIN takes effect at the next edge: all strobes are low in the following cycle, and no `tile_done` is issued.
- **Control outputs:**
  - `feed_load`, `feed_shift`, `lane_valid`, `busy` and `tile_done` are registered outputs.
  - `in_ready` is decoded combinationally from state.
- **Latency (defaults):**
  - The last row is accepted at edge E.
  - `feed_load[0]` is high in cycle E+1.
  - The last `lane_valid[6]` is in stream cycle t=13, which is E+14.
  - DRAIN occupies E+15..E+21, and `tile_done` is in E+21.
  - `in_ready` rises in E+22.
- **Tile length:** the minimum from the first accept to `tile_done` is N_LANES + (N_LANES+VEC_LEN) + DRAIN_CYCLES cycles. With defaults this is 7+14+7=28.

## Configuration
- **`FEED_SEQ_STATS_EN`:**
  - When defined, adds output `tiles_done` [15:0]. It resets to 0 and increments on each `tile_done`, wrapping 0xFFFF→0.
  - It also adds output `stall_cycles` [15:0]. It resets to 0 and increments, saturating at 0xFFFF, on every cycle in which `in_valid`=1 and `in_ready`=0.
- **Undefined:** these ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- **Reset:** hold reset 2 cycles, then check all outputs against the reset values, with `in_ready`=1 and `feed_data`=0.
- **Single tile:** send rows 0x01..07, 0x11..17, …, 0x71..77 back-to-back. Check:
  - `feed_load` = 0000001, 0000010, … 1000000 in E+1..E+7.
  - `lane_valid[3]` is high exactly over E+5..E+11.
  - `tile_done` is in E+21.
- **Gapped input:** deassert `in_valid` for 3 cycles between rows 2 and 3. Check that row_cnt holds and that STREAM starts one cycle after the 7th accept.
- **Back-pressure:** hold `in_valid`=1 with row 0xAA… through STREAM/DRAIN. Check:
  - `in_ready`=0 throughout.
  - The bank is unchanged.
  - The row is accepted as row 0 of the next tile in E+22.
- **Mid-stream reset:** assert reset at t=5. Check that the next cycle has all strobes 0, `feed_data`=0 and state IDLE, and that no `tile_done` follows.
- **Stats (with `FEED_SEQ_STATS_EN`):** run 3 tiles with the back-pressure stimulus. Check `tiles_done`=3 and that `stall_cycles` equals the counted stalled cycles (21 per tile where offered).
